fetch_interrupt_injector: RTL and testbench



---
 rtl/fetch_interrupt_injector_if.sv | 27 ++
 rtl/fetch_interrupt_injector.sv | 146 ++++++++++++++
 tb/tb_fetch_interrupt_injector.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_interrupt_injector_if.sv
// Fetch-side bundle of the interrupt injector: controller handshake plus fetch/decode signals.
// master = controller/pipeline side, slave = injector.
interface fetch_interrupt_injector_if;
  logic        INT;
  logic [31:0] INT_INSTR;
  logic        ACK;
  logic [31:0] imem_instr;
  logic [31:0] pc_in;
  logic        stall;
  logic        iret;
  logic [31:0] instr_out;
  logic        pc_hold;
  logic        pc_restore;
  logic [31:0] epc;
  logic        in_isr;
  logic        err_timeout;

  modport master (
    output INT, INT_INSTR, imem_instr, pc_in, stall, iret,
    input  ACK, instr_out, pc_hold, pc_restore, epc, in_isr, err_timeout
  );

  modport slave (
    input  INT, INT_INSTR, imem_instr, pc_in, stall, iret,
    output ACK, instr_out, pc_hold, pc_restore, epc, in_isr, err_timeout
  );
endinterface

// File: rtl/fetch_interrupt_injector.sv
// Substitutes the interrupt controller's NOP+jump stream for imem words; optional ISR watchdog under ISR_TIMEOUT_EN.
// Latency: a captured stream word reaches instr_out one cycle after capture at the earliest.
// Backpressure: stall only gates draining; capture is unconditional and buffered, so no controller word is dropped.
module fetch_interrupt_injector #(
  parameter int          NOP_COUNT   = 5,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] INSTR_NOOP  = 32'h78000000,
  parameter int          ISR_TIMEOUT = 4096
) (
  input logic                        clk,
  input logic                        rst,
  fetch_interrupt_injector_if.slave  bus
);

  localparam int STREAM_LEN = NOP_COUNT + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int KW = $clog2(STREAM_LEN + 1);

  generate
    if (FIFO_DEPTH < STREAM_LEN) begin : g_depth_chk
      $error("FIFO_DEPTH must be >= NOP_COUNT+1");
    end
    if (ISR_TIMEOUT < 1 || ISR_TIMEOUT > 65535) begin : g_tmo_chk
      $error("ISR_TIMEOUT must fit the 16-bit ISR counter");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, ACCEPT, INJECT, IN_ISR, RETURN} state_t;

  state_t          state, state_nxt;
  logic [31:0]     buf_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   buf_cnt;
  logic [KW-1:0]   cap_cnt;
  logic [31:0]     epc_q;
  logic            push, pop, buf_empty, cap_done, leave_inject, timeout_hit;
  logic            ack, pc_hold, pc_restore, in_isr;
  logic [31:0]     instr_out;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign buf_empty = (buf_cnt == '0);
  assign cap_done  = (cap_cnt == KW'(STREAM_LEN));
  assign push      = (state == INJECT) && !cap_done;
  assign pop       = (state == INJECT) && !bus.stall && !buf_empty;
  // The jump leaves the buffer this cycle: release the PC so it can redirect.
  assign leave_inject = cap_done && (buf_empty || (buf_cnt == CW'(1) && pop));

  always_comb begin
    state_nxt  = state;
    ack        = 1'b0;
    pc_hold    = 1'b0;
    pc_restore = 1'b0;
    in_isr     = 1'b0;
    instr_out  = bus.imem_instr;
    case (state)
      IDLE: begin
        if (bus.INT && !bus.stall) state_nxt = ACCEPT;
      end
      ACCEPT: begin
        ack       = 1'b1;
        pc_hold   = 1'b1;
        instr_out = INSTR_NOOP;
        state_nxt = INJECT;
      end
      INJECT: begin
        instr_out = buf_empty ? INSTR_NOOP : buf_mem[rd_ptr];
        pc_hold   = !leave_inject;
        if (leave_inject) state_nxt = IN_ISR;
      end
      IN_ISR: begin
        in_isr = 1'b1;
        if ((bus.iret && !bus.stall) || timeout_hit) state_nxt = RETURN;
      end
      RETURN: begin
        ack        = 1'b1;
        pc_restore = 1'b1;
        in_isr     = 1'b1;
        instr_out  = INSTR_NOOP;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      epc_q   <= '0;
      cap_cnt <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      buf_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == ACCEPT) epc_q <= bus.pc_in;
      if (state == ACCEPT) cap_cnt <= '0;
      else if (push)       cap_cnt <= cap_cnt + 1'b1;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + 1'b1;
        2'b01:   buf_cnt <= buf_cnt - 1'b1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr] <= bus.INT_INSTR;
  end

`ifdef ISR_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        err_q;

  assign timeout_hit = (state == IN_ISR) && (tmo_cnt == 16'(ISR_TIMEOUT - 1))
                       && !(bus.iret && !bus.stall);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (state == IN_ISR) ? tmo_cnt + 1'b1 : '0;
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign bus.err_timeout = err_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.ACK        = ack;
  assign bus.pc_hold    = pc_hold;
  assign bus.pc_restore = pc_restore;
  assign bus.in_isr     = in_isr;
  assign bus.instr_out  = instr_out;
  assign bus.epc        = epc_q;

endmodule

// File: tb/tb_fetch_interrupt_injector.sv
// Randomized bench for fetch_interrupt_injector; reference is a queue model of the injected stream.
module tb_fetch_interrupt_injector;
  localparam int          NOP_COUNT  = 5;
  localparam int          FIFO_DEPTH = 8;
  localparam logic [31:0] NOOP       = 32'h78000000;
  localparam int          TMO        = 16;
  localparam int          SLEN       = NOP_COUNT + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_interrupt_injector_if bus();

  fetch_interrupt_injector #(
    .NOP_COUNT(NOP_COUNT), .FIFO_DEPTH(FIFO_DEPTH), .INSTR_NOOP(NOOP), .ISR_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] epc_exp = 32'h0;

  task automatic test_reset();
    logic [31:0] im;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.INT = 1'b0; bus.iret = 1'b0; bus.stall = 1'b0;
    im = $urandom; bus.imem_instr = im;
    #1;
    n_vec++;
    if ({bus.ACK, bus.pc_hold, bus.pc_restore, bus.in_isr, bus.err_timeout} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags got %b exp 00000",
        {bus.ACK, bus.pc_hold, bus.pc_restore, bus.in_isr, bus.err_timeout});
    end
    n_vec++;
    if (bus.epc !== 32'h0) begin n_err++; $display("FAIL reset_epc got %h exp 0", bus.epc); end
    n_vec++;
    if (bus.instr_out !== im) begin n_err++; $display("FAIL reset_instr got %h exp %h", bus.instr_out, im); end
    epc_exp = 32'h0;
  endtask

  // Accept + injection from IDLE; abort_at>0 asserts rst once that many words were captured.
  task automatic test_inject(input logic [31:0] pc, input bit plan, input int stall_pct,
                             input bit stall_fixed, input int wait_stall_pct, input int abort_at);
    logic [31:0] stream [SLEN+1];
    logic [31:0] q [$];
    logic [31:0] im, exp_out;
    int k, popped;
    bit sent, leaving, pop, aborted;
    for (int i = 0; i <= SLEN; i++) stream[i] = plan ? ((i == NOP_COUNT) ? 32'hA0000004 : NOOP) : $urandom;
    sent = 1'b0;
    for (int w = 0; w < 20 && !sent; w++) begin
      @(negedge clk);
      bus.INT = 1'b1; bus.pc_in = pc; bus.iret = 1'($urandom); bus.INT_INSTR = $urandom;
      bus.stall = (w < 19) && (int'($urandom_range(99)) < wait_stall_pct);
      im = $urandom; bus.imem_instr = im;
      #1;
      n_vec++;
      if ({bus.ACK, bus.pc_hold, bus.pc_restore, bus.in_isr} !== 4'b0000 || bus.instr_out !== im) begin
        n_err++; $display("FAIL idle_wait flags=%b instr=%h exp flags=0000 instr=%h",
          {bus.ACK, bus.pc_hold, bus.pc_restore, bus.in_isr}, bus.instr_out, im);
      end
      sent = !bus.stall;
    end
    @(negedge clk);
    bus.INT = 1'($urandom); bus.stall = 1'($urandom); bus.iret = 1'($urandom); bus.imem_instr = $urandom;
    #1;
    epc_exp = pc;
    n_vec++;
    if ({bus.ACK, bus.pc_hold, bus.pc_restore, bus.in_isr} !== 4'b1100 || bus.instr_out !== NOOP) begin
      n_err++; $display("FAIL accept flags=%b instr=%h exp flags=1100 instr=%h",
        {bus.ACK, bus.pc_hold, bus.pc_restore, bus.in_isr}, bus.instr_out, NOOP);
    end
    n_vec++;
    if (bus.epc !== epc_exp) begin n_err++; $display("FAIL accept_epc got %h exp %h", bus.epc, epc_exp); end
    k = 0; popped = 0; leaving = 1'b0; aborted = 1'b0;
    for (int c = 0; c < 60 && !leaving; c++) begin
      @(negedge clk);
      bus.INT = 1'($urandom); bus.iret = 1'($urandom); bus.imem_instr = $urandom;
      bus.stall = stall_fixed ? (c >= 2 && c < 6) : (int'($urandom_range(99)) < stall_pct);
      bus.INT_INSTR = (k < SLEN) ? stream[k] : $urandom;
      if (abort_at > 0 && k == abort_at) begin
        rst = 1'b1; aborted = 1'b1;
        break;
      end
      #1;
      exp_out = (q.size() > 0) ? q[0] : NOOP;
      pop = !bus.stall && (q.size() > 0);
      leaving = (k == SLEN) && (q.size() == (pop ? 1 : 0));
      n_vec++;
      if (bus.instr_out !== exp_out) begin
        n_err++; $display("FAIL inject_instr cyc=%0d got %h exp %h", c, bus.instr_out, exp_out);
      end
      n_vec++;
      if ({bus.ACK, bus.pc_hold, bus.pc_restore, bus.in_isr} !== {1'b0, !leaving, 2'b00}) begin
        n_err++; $display("FAIL inject_flags cyc=%0d got %b exp %b", c,
          {bus.ACK, bus.pc_hold, bus.pc_restore, bus.in_isr}, {1'b0, !leaving, 2'b00});
      end
      if (pop) begin void'(q.pop_front()); popped++; end
      if (k < SLEN) begin q.push_back(stream[k]); k++; end
    end
    if (aborted) return;
    n_vec++;
    if (!leaving || popped != SLEN) begin
      n_err++; $display("FAIL inject_done drained=%0d exp %0d", popped, SLEN);
    end
    @(negedge clk);
    bus.INT = 1'b1; bus.iret = 1'b0; bus.stall = 1'($urandom);
    im = $urandom; bus.imem_instr = im;
    #1;
    n_vec++;
    if ({bus.ACK, bus.pc_hold, bus.pc_restore, bus.in_isr} !== 4'b0001 || bus.instr_out !== im) begin
      n_err++; $display("FAIL isr_entry flags=%b instr=%h exp flags=0001 instr=%h",
        {bus.ACK, bus.pc_hold, bus.pc_restore, bus.in_isr}, bus.instr_out, im);
    end
  endtask

  task automatic test_return(input bit hold_int, input int isr_cycles);
    logic [31:0] im;
    for (int i = 0; i <= isr_cycles; i++) begin
      @(negedge clk);
      bus.INT = hold_int ? 1'b1 : 1'($urandom);
      if (i == isr_cycles) begin bus.iret = 1'b1; bus.stall = 1'b0; end
      else begin bus.iret = 1'($urandom); bus.stall = bus.iret ? 1'b1 : 1'($urandom); end
      im = $urandom; bus.imem_instr = im;
      #1;
      n_vec++;
      if ({bus.ACK, bus.pc_hold, bus.pc_restore, bus.in_isr} !== 4'b0001 || bus.instr_out !== im) begin
        n_err++; $display("FAIL isr_body i=%0d flags=%b instr=%h exp flags=0001 instr=%h", i,
          {bus.ACK, bus.pc_hold, bus.pc_restore, bus.in_isr}, bus.instr_out, im);
      end
    end
    @(negedge clk);
    bus.iret = 1'b0; bus.INT = hold_int; bus.stall = 1'($urandom); bus.imem_instr = $urandom;
    #1;
    n_vec++;
    if ({bus.ACK, bus.pc_hold, bus.pc_restore} !== 3'b101 || bus.epc !== epc_exp) begin
      n_err++; $display("FAIL return ack/hold/restore=%b epc=%h exp 101 epc=%h",
        {bus.ACK, bus.pc_hold, bus.pc_restore}, bus.epc, epc_exp);
    end
    if (!hold_int) begin
      @(negedge clk);
      bus.INT = 1'b0; bus.stall = 1'($urandom);
      im = $urandom; bus.imem_instr = im;
      #1;
      n_vec++;
      if ({bus.ACK, bus.pc_hold, bus.pc_restore, bus.in_isr} !== 4'b0000 || bus.instr_out !== im) begin
        n_err++; $display("FAIL post_return flags=%b instr=%h exp flags=0000 instr=%h",
          {bus.ACK, bus.pc_hold, bus.pc_restore, bus.in_isr}, bus.instr_out, im);
      end
    end
  endtask

  task automatic test_iret_idle();
    logic [31:0] im;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.INT = 1'b0; bus.iret = 1'b1; bus.stall = 1'($urandom);
      im = $urandom; bus.imem_instr = im;
      #1;
      n_vec++;
      if ({bus.ACK, bus.pc_hold, bus.pc_restore, bus.in_isr} !== 4'b0000 || bus.instr_out !== im) begin
        n_err++; $display("FAIL iret_idle flags=%b instr=%h exp flags=0000 instr=%h",
          {bus.ACK, bus.pc_hold, bus.pc_restore, bus.in_isr}, bus.instr_out, im);
      end
    end
    bus.iret = 1'b0;
  endtask

  task automatic test_back_to_back();
    // INT stays high through RETURN: one IDLE cycle, then the next accept.
    test_inject(32'h0000_2000, 1'b0, 20, 1'b0, 0, 0);
    test_return(1'b1, 3);
    test_inject(32'h0000_3000, 1'b0, 20, 1'b0, 0, 0);
    test_return(1'b0, 2);
  endtask

  task automatic test_reset_mid();
    logic [31:0] im;
    test_inject(32'h0000_4000, 1'b0, 0, 1'b0, 0, 3);
    @(negedge clk);
    rst = 1'b0; bus.INT = 1'b0; bus.iret = 1'b0; bus.stall = 1'b0;
    im = $urandom; bus.imem_instr = im;
    #1;
    n_vec++;
    if ({bus.ACK, bus.pc_hold, bus.pc_restore, bus.in_isr, bus.err_timeout} !== 5'b0
        || bus.epc !== 32'h0 || bus.instr_out !== im) begin
      n_err++; $display("FAIL reset_mid flags=%b epc=%h instr=%h exp flags=00000 epc=0 instr=%h",
        {bus.ACK, bus.pc_hold, bus.pc_restore, bus.in_isr, bus.err_timeout}, bus.epc, bus.instr_out, im);
    end
    epc_exp = 32'h0;
    // A fresh injection must not see leftover words from the aborted one.
    test_inject(32'h0000_5000, 1'b0, 30, 1'b0, 0, 0);
    test_return(1'b0, 2);
  endtask

`ifdef ISR_TIMEOUT_EN
  task automatic test_timeout();
    test_inject(32'h0000_6000, 1'b0, 0, 1'b0, 0, 0);
    for (int i = 1; i < TMO; i++) begin
      @(negedge clk);
      bus.iret = 1'b0; bus.INT = 1'($urandom); bus.stall = 1'($urandom);
      #1;
      n_vec++;
      if ({bus.ACK, bus.pc_restore, bus.in_isr, bus.err_timeout} !== 4'b0010) begin
        n_err++; $display("FAIL tmo_wait i=%0d got %b exp 0010", i,
          {bus.ACK, bus.pc_restore, bus.in_isr, bus.err_timeout});
      end
    end
    @(negedge clk);
    bus.INT = 1'b0;
    #1;
    n_vec++;
    if ({bus.ACK, bus.pc_restore, bus.err_timeout} !== 3'b111 || bus.epc !== epc_exp) begin
      n_err++; $display("FAIL tmo_return got %b epc=%h exp 111 epc=%h",
        {bus.ACK, bus.pc_restore, bus.err_timeout}, bus.epc, epc_exp);
    end
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if ({bus.in_isr, bus.err_timeout} !== 2'b01) begin
      n_err++; $display("FAIL tmo_sticky got %b exp 01", {bus.in_isr, bus.err_timeout});
    end
    test_reset();
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.INT = 1'b0; bus.INT_INSTR = '0; bus.imem_instr = '0; bus.pc_in = '0;
    bus.stall = 1'b0; bus.iret = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_inject(32'h0000_0100, 1'b1, 0, 1'b0, 0, 0);
    test_return(1'b0, 4);
    test_iret_idle();
    test_inject(32'h0000_0100, 1'b1, 0, 1'b1, 0, 0);
    test_return(1'b0, 3);
    for (int r = 0; r < 12; r++) begin
      test_inject($urandom & 32'hFFFF_FFFC, 1'b0, int'($urandom_range(70)), 1'b0, 30, 0);
      test_return(1'b0, 1 + int'($urandom_range(6)));
    end
    test_back_to_back();
    test_reset_mid();
`ifdef ISR_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
